field_serializer: RTL and testbench
===================================

# field_serializer

Sits on the output side of the field FIFO and turns its wide, lane-parallel bundle of decoded FAST fields into a single ordered field stream for the book and strategy logic. Each cycle it can accept up to NUM_DECODERS field entries. It packs the valid lanes in lane order into a circular buffer. It then emits one field per cycle over a valid/ready handshake, marking the first and last field of each message.

## Interface
- NUM_DECODERS, 4, lanes per input bundle.
- BEAT_WIDTH, 64, field data width B.
- MAX_MESSAGE_SIZE, 10, max fields per message. L = $clog2(MAX_MESSAGE_SIZE).
- MESSAGEID_SIZE, 21, message ID width M.
- DEPTH, 16, buffer entries. Must be a power of 2 and ≥ NUM_DECODERS.
- Entry width E = 2+M+L+B. Layout from MSB down: valid[1], last[1], msg_id[M], field_idx[L], data[B].

Ports:
- clk  in  1  clock. Everything is rising-edge.
- rstn  in  1  reset; synchronous, active-low.
- in_fields  in  E × [0:NUM_DECODERS-1]  input bundle. Each lane is qualified by its own valid bit.
- in_ready  out  1  bundle is accepted this cycle.
- out_valid  out  1  head entry is present.
- out_ready  in  1  consumer takes the head.
- out_msg_id  out  M  head message ID.
- out_field_idx  out  L  head field index.
- out_data  out  B  head field data.
- out_first  out  1  head is the first field of a new message.
- out_last  out  1  head carries last=1.
- fill_level  out  $clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky; a valid lane was dropped.

## Operation
- Storage is a circular buffer of DEPTH entries. It has wr_ptr, rd_ptr ($clog2(DEPTH) bits each, wrapping naturally) and count.
- in_ready = (DEPTH − count) ≥ NUM_DECODERS. It is computed only from the registered count. A pop in the same cycle does not raise it.
- Push: when in_ready=1, the valid lanes are written at wr_ptr, wr_ptr+1, … in ascending lane order, skipping invalid lanes.
  - Example: lanes 1 and 3 valid → lane 1 goes to wr_ptr and lane 3 goes to wr_ptr+1.
  - wr_ptr advances by popcount(valid lanes) mod DEPTH.
- A bundle with no valid lanes is a no-op and never sets overflow.
- Drop: when in_ready=0 and any lane is valid, the whole bundle is discarded and overflow is set. overflow clears only on reset.
- Pop: when out_valid && out_ready, rd_ptr advances by 1.
- count_next = count + pushed − popped. Push and pop in the same cycle are legal and both take effect.
- out_valid = (count ≠ 0).
- out_msg_id, out_field_idx, out_data and out_last reflect the entry at rd_ptr. When out_valid=0 they are held at 0.
- out_first:
  - Registers prev_id and prev_known track the last popped entry.
  - out_first = out_valid && (!prev_known || prev_popped_last || out_msg_id ≠ prev_id).
  - On each pop: prev_id ← head msg_id, prev_popped_last ← head last, prev_known ← 1.
- Outputs are stable while out_valid && !out_ready. The head does not change under backpressure.

## Timing
- Reset, on any clk edge with rstn=0, regardless of state:
  - count, wr_ptr, rd_ptr, prev_known, prev_popped_last, overflow ← 0.
  - Outputs: out_valid=0, all out_* fields=0, fill_level=0, in_ready=1, overflow=0.
  - Buffer contents do not need clearing.
- If reset is asserted mid-stream, every in-flight entry is lost and the next accepted field is flagged out_first.
- Latency: a bundle accepted at edge t gives out_valid=1 in the cycle after edge t, provided the buffer was empty.
- Throughput: at most NUM_DECODERS pushes and 1 pop per cycle.
- Wrap-around: a push that crosses index DEPTH−1 continues at index 0 with order preserved.
- Full: when count=DEPTH, in_ready=0 and pops continue normally.
- When count > DEPTH−NUM_DECODERS, in_ready=0 even though some slots are free. Partial bundles are never accepted.

## Test plan
- Reset check: hold rstn=0 for 2 cycles with out_ready=1.
  - Required: out_valid=0, fill_level=0, in_ready=1, overflow=0.
  - Push one lane {msg 5, idx 0, data 0xAA}. Next cycle required: out_valid=1, out_first=1, out_data=0xAA.
- Compaction: push one bundle with lanes 1 and 3 valid (data 0x11, 0x33).
  - Required: fill_level=2, then pops in order 0x11, 0x33.
  - Zero-valid bundle afterwards: no change to fill_level.
- Backpressure and overflow: out_ready=0, push 4 full bundles of 4 lanes. Required: fill_level=16 and in_ready=0.
  - Push a 5th bundle. Required: overflow=1, fill_level stays 16.
  - Drain all 16. Required: the original order is preserved and overflow stays 1.
- Simultaneous push and pop at count=12: push 4 lanes with out_ready=1.
  - Required: fill_level=15 next cycle and in_ready=0 next cycle.
- Wrap-around: repeat push 3 / pop 3 so that wr_ptr crosses 15→0 at least 5 times.
  - Required: output data sequence is strictly incrementing with no gaps.
- Message framing: stream msg 7 fields idx 0..2 (idx 2 last=1), then msg 7 idx 0, then msg 9 idx 0.
  - Required out_first pattern: 1,0,0,1,1.
  - Required out_last: 1 only on the third field.
  - Assert rstn=0 mid-stream. Required: the next field shows out_first=1.

Source files
------------

// File: rtl/field_serializer.sv
// Packs the valid lanes of each wide decoded-field bundle into a circular buffer
// and replays them one field per cycle, with first/last-of-message framing.
module field_serializer #(
  parameter int unsigned NUM_DECODERS     = 4,
  parameter int unsigned BEAT_WIDTH       = 64,
  parameter int unsigned MAX_MESSAGE_SIZE = 10,
  parameter int unsigned MESSAGEID_SIZE   = 21,
  parameter int unsigned DEPTH            = 16,
  localparam int unsigned L  = $clog2(MAX_MESSAGE_SIZE),
  localparam int unsigned E  = 2 + MESSAGEID_SIZE + L + BEAT_WIDTH,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [E-1:0]              in_fields [0:NUM_DECODERS-1],
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MESSAGEID_SIZE-1:0] out_msg_id,
  output logic [L-1:0]              out_field_idx,
  output logic [BEAT_WIDTH-1:0]     out_data,
  output logic                      out_first,
  output logic                      out_last,
  output logic [CW-1:0]             fill_level,
  output logic                      overflow
);

  localparam int unsigned NW = $clog2(NUM_DECODERS + 1);
  localparam int unsigned SW = E - 1;  // stored entry drops the lane-valid bit

  logic [SW-1:0]             mem [DEPTH];
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [CW-1:0]             count;
  logic                      prev_known;
  logic                      prev_popped_last;
  logic [MESSAGEID_SIZE-1:0] prev_id;

  logic [NW-1:0] num_valid;
  logic [PW-1:0] lane_addr [NUM_DECODERS];
  logic          any_valid;
  logic          push;
  logic          pop;
  logic [SW-1:0] head;

  // Compaction: each valid lane lands at wr_ptr plus the number of valid lanes below it.
  always_comb begin
    num_valid = '0;
    for (int i = 0; i < NUM_DECODERS; i++) begin
      lane_addr[i] = wr_ptr + PW'(num_valid);
      num_valid    = num_valid + NW'(in_fields[i][E-1]);
    end
  end

  assign any_valid = (num_valid != '0);
  assign in_ready  = (CW'(DEPTH) - count) >= CW'(NUM_DECODERS);
  assign push      = in_ready && any_valid;
  assign pop       = out_valid && out_ready;

  assign head          = mem[rd_ptr];
  assign out_valid     = (count != '0);
  assign out_last      = out_valid && head[SW-1];
  assign out_msg_id    = out_valid ? head[SW-2 -: MESSAGEID_SIZE] : '0;
  assign out_field_idx = out_valid ? head[BEAT_WIDTH+L-1 -: L] : '0;
  assign out_data      = out_valid ? head[BEAT_WIDTH-1:0] : '0;
  assign out_first     = out_valid && (!prev_known || prev_popped_last || (out_msg_id != prev_id));
  assign fill_level    = count;

  // Buffer storage; contents are don't-care after reset since pointers are cleared.
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      for (int i = 0; i < NUM_DECODERS; i++) begin
        if (in_fields[i][E-1]) mem[lane_addr[i]] <= in_fields[i][SW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      prev_known       <= 1'b0;
      prev_popped_last <= 1'b0;
      prev_id          <= '0;
      overflow         <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(num_valid);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (push ? CW'(num_valid) : CW'(0)) - CW'(pop);
      // A bundle that cannot fit whole is dropped entirely.
      if (!in_ready && any_valid) overflow <= 1'b1;
      if (pop) begin
        prev_known       <= 1'b1;
        prev_popped_last <= head[SW-1];
        prev_id          <= head[SW-2 -: MESSAGEID_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_field_serializer.sv
// Scoreboard bench for field_serializer: a reference model predicts occupancy,
// flags and the popped field stream, including first/last framing.
module tb_field_serializer;

  localparam int unsigned ND = 4;
  localparam int unsigned M  = 21;
  localparam int unsigned L  = 4;
  localparam int unsigned B  = 64;
  localparam int unsigned E  = 2 + M + L + B;
  localparam int unsigned DP = 16;

  typedef struct {
    logic [M-1:0] id;
    logic [L-1:0] idx;
    logic [B-1:0] data;
    logic         last;
  } exp_t;

  logic          clk;
  logic          rstn;
  logic [E-1:0]  lanes [0:ND-1];
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  out_msg_id;
  logic [L-1:0]  out_field_idx;
  logic [B-1:0]  out_data;
  logic          out_first;
  logic          out_last;
  logic [4:0]    fill_level;
  logic          overflow;

  field_serializer dut (
    .clk(clk), .rstn(rstn), .in_fields(lanes), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg_id(out_msg_id),
    .out_field_idx(out_field_idx), .out_data(out_data), .out_first(out_first),
    .out_last(out_last), .fill_level(fill_level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t   sb [$];
  logic   log_first [$];
  logic   log_last [$];
  int     m_count;
  logic   m_ovf, m_pk, m_pl;
  logic [M-1:0] m_pid;
  longint dcnt = 64'h100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [E-1:0] mk(input logic last, input logic [M-1:0] id,
                                      input logic [L-1:0] idx, input logic [B-1:0] d);
    return {1'b1, last, id, idx, d};
  endfunction

  task automatic clear_lanes();
    for (int i = 0; i < ND; i++) lanes[i] = '0;
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0; m_ovf = 1'b0; m_pk = 1'b0; m_pl = 1'b0; m_pid = '0;
  endtask

  // One clock: check flags, score a pop, model the push, then advance.
  task automatic tick();
    int   nv;
    logic m_ready;
    logic popped;
    logic exp_first;
    exp_t e;
    m_ready = (DP - m_count) >= ND;
    popped  = 1'b0;
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("fill_level", 64'(fill_level), 64'(m_count));
    chk("out_valid", 64'(out_valid), 64'(m_count != 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (m_count != 0 && out_ready && sb.size() != 0) begin
      e = sb.pop_front();
      exp_first = !m_pk || m_pl || (e.id != m_pid);
      chk("out_data", out_data, e.data);
      chk("out_msg_id", 64'(out_msg_id), 64'(e.id));
      chk("out_field_idx", 64'(out_field_idx), 64'(e.idx));
      chk("out_last", 64'(out_last), 64'(e.last));
      chk("out_first", 64'(out_first), 64'(exp_first));
      log_first.push_back(out_first);
      log_last.push_back(out_last);
      m_pk = 1'b1; m_pl = e.last; m_pid = e.id;
      popped = 1'b1;
    end
    nv = 0;
    for (int i = 0; i < ND; i++) if (lanes[i][E-1]) nv++;
    if (nv > 0) begin
      if (m_ready) begin
        for (int i = 0; i < ND; i++) begin
          if (lanes[i][E-1]) begin
            e.last = lanes[i][E-2];
            e.id   = lanes[i][E-3 -: M];
            e.idx  = lanes[i][B+L-1 -: L];
            e.data = lanes[i][B-1:0];
            sb.push_back(e);
          end
        end
        m_count += nv;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (popped) m_count--;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_lanes();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rstn = 1'b1;
  endtask

  task automatic push_full(input logic [M-1:0] id);
    for (int i = 0; i < ND; i++) begin
      lanes[i] = mk(1'b0, id, L'(i), 64'(dcnt));
      dcnt++;
    end
    tick();
    clear_lanes();
  endtask

  initial begin
    logic exp_f [5];
    logic exp_l [5];
    rstn = 1'b0;
    out_ready = 1'b1;
    clear_lanes();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fill_level", 64'(fill_level), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    rstn = 1'b1;

    // First field after reset
    lanes[0] = mk(1'b0, 21'd5, 4'd0, 64'hAA);
    tick();
    clear_lanes();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_flag", 64'(out_first), 64'd1);
    chk("first_data", out_data, 64'hAA);
    tick();

    // Compaction of lanes 1 and 3
    out_ready = 1'b0;
    lanes[1] = mk(1'b0, 21'd6, 4'd0, 64'h11);
    lanes[3] = mk(1'b0, 21'd6, 4'd1, 64'h33);
    tick();
    clear_lanes();
    chk("compact_fill", 64'(fill_level), 64'd2);
    tick();
    chk("zero_bundle_fill", 64'(fill_level), 64'd2);
    out_ready = 1'b1;
    repeat (2) tick();

    // Backpressure, full and overflow
    out_ready = 1'b0;
    repeat (4) push_full(21'd20);
    chk("full_fill", 64'(fill_level), 64'd16);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    push_full(21'd20);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_fill", 64'(fill_level), 64'd16);
    out_ready = 1'b1;
    repeat (16) tick();
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Simultaneous push and pop at count 12
    out_ready = 1'b0;
    repeat (3) push_full(21'd21);
    chk("pre_sim_fill", 64'(fill_level), 64'd12);
    out_ready = 1'b1;
    push_full(21'd21);
    chk("sim_fill", 64'(fill_level), 64'd15);
    chk("sim_in_ready", 64'(in_ready), 64'd0);
    repeat (15) tick();

    // Wrap-around: push 3 / pop 3, wr_ptr wraps many times
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 3; i++) begin
        lanes[i] = mk(1'b0, 21'd3, L'(i), 64'(dcnt));
        dcnt++;
      end
      tick();
      clear_lanes();
      repeat (3) tick();
    end
    chk("wrap_drained", 64'(fill_level), 64'd0);

    // Message framing
    log_first.delete();
    log_last.delete();
    out_ready = 1'b0;
    lanes[0] = mk(1'b0, 21'd7, 4'd0, 64'h700);
    lanes[1] = mk(1'b0, 21'd7, 4'd1, 64'h701);
    lanes[2] = mk(1'b1, 21'd7, 4'd2, 64'h702);
    lanes[3] = mk(1'b0, 21'd7, 4'd0, 64'h710);
    tick();
    clear_lanes();
    lanes[0] = mk(1'b0, 21'd9, 4'd0, 64'h900);
    tick();
    clear_lanes();
    out_ready = 1'b1;
    repeat (5) tick();
    exp_f = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    chk("frame_count", 64'(log_first.size()), 64'd5);
    for (int i = 0; i < 5 && i < log_first.size(); i++) begin
      chk($sformatf("frame_first[%0d]", i), 64'(log_first[i]), 64'(exp_f[i]));
      chk($sformatf("frame_last[%0d]", i), 64'(log_last[i]), 64'(exp_l[i]));
    end

    // Reset mid-stream drops in-flight fields and restarts framing
    out_ready = 1'b0;
    lanes[0] = mk(1'b0, 21'd9, 4'd1, 64'h901);
    lanes[1] = mk(1'b0, 21'd9, 4'd2, 64'h902);
    tick();
    clear_lanes();
    do_reset();
    chk("midrst_fill", 64'(fill_level), 64'd0);
    lanes[0] = mk(1'b0, 21'd9, 4'd3, 64'h903);
    tick();
    clear_lanes();
    chk("midrst_first", 64'(out_first), 64'd1);
    chk("midrst_data", out_data, 64'h903);
    out_ready = 1'b1;
    repeat (2) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
